// File: rtl/stream_patchifier_pkg.sv
// Shared sizing helpers and types for the streaming patchifier.
// Derived localparams describe the default 64x64 / 16-pixel-patch configuration.
package stream_patchifier_pkg;

    function automatic int pixel_width(input int channel_size, input int num_channels);
        return channel_size * num_channels;
    endfunction

    // Index width that never collapses to zero bits for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CHANNEL_SIZE = 8;
    localparam int DEF_NUM_CHANNELS = 3;
    localparam int DEF_IMG_WIDTH    = 64;
    localparam int DEF_IMG_HEIGHT   = 64;
    localparam int DEF_PATCH_SIZE   = 16;

    localparam int PATCHES_IN_ROW = DEF_IMG_WIDTH / DEF_PATCH_SIZE;
    localparam int TOTAL_PATCHES  = PATCHES_IN_ROW * (DEF_IMG_HEIGHT / DEF_PATCH_SIZE);
    localparam int PATCH_VEC      = DEF_PATCH_SIZE * DEF_PATCH_SIZE;

    localparam int PATCH_IDX_W = idx_width(TOTAL_PATCHES);
    localparam int POS_IDX_W   = idx_width(PATCH_VEC);

    // One full flag per ping-pong bank.
    typedef logic [1:0] bank_status_t;

endpackage

// File: rtl/stream_patchifier_band_buffer.sv
// Ping-pong band storage: two banks of PATCH_SIZE rows x IMG_WIDTH pixels.
// Single write port, single asynchronous read port, independent bank selects.
module patch_band_buffer
    import stream_patchifier_pkg::*;
#(
    parameter int PIXEL_WIDTH = 24,
    parameter int PATCH_SIZE  = 16,
    parameter int IMG_WIDTH   = 64
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic                              wr_bank,
    input  logic [idx_width(PATCH_SIZE)-1:0]  wr_row,
    input  logic [idx_width(IMG_WIDTH)-1:0]   wr_col,
    input  logic [PIXEL_WIDTH-1:0]            wr_pixel,
    input  logic                              rd_bank,
    input  logic [idx_width(PATCH_SIZE)-1:0]  rd_row,
    input  logic [idx_width(IMG_WIDTH)-1:0]   rd_col,
    output logic [PIXEL_WIDTH-1:0]            rd_pixel
);

    logic [PIXEL_WIDTH-1:0] mem [2][PATCH_SIZE][IMG_WIDTH];

    // Pixel storage; contents are qualified by the bank full flags, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_row][wr_col] <= wr_pixel;
        end
    end

    assign rd_pixel = mem[rd_bank][rd_row][rd_col];

endmodule

// File: rtl/stream_patchifier.sv
// Raster-order pixel stream in, patch-major pixel stream out, with valid/ready
// on both sides and a ping-pong pair of band buffers between them.
module stream_patchifier
    import stream_patchifier_pkg::*;
#(
    parameter int CHANNEL_SIZE = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int IMG_WIDTH    = 64,
    parameter int IMG_HEIGHT   = 64,
    parameter int PATCH_SIZE   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic [pixel_width(CHANNEL_SIZE, NUM_CHANNELS)-1:0] in_pixel,
    input  logic in_sof,
    output logic out_valid,
    input  logic out_ready,
    output logic [pixel_width(CHANNEL_SIZE, NUM_CHANNELS)-1:0] out_pixel,
    output logic [idx_width((IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE))-1:0] out_patch_idx,
    output logic [idx_width(PATCH_SIZE*PATCH_SIZE)-1:0] out_pos_idx,
    output logic out_last_patch,
    output logic out_last_frame,
    output logic sof_err
);

    localparam int PW      = pixel_width(CHANNEL_SIZE, NUM_CHANNELS);
    localparam int PIR     = IMG_WIDTH / PATCH_SIZE;
    localparam int NBANDS  = IMG_HEIGHT / PATCH_SIZE;
    localparam int TP      = PIR * NBANDS;
    localparam int PV      = PATCH_SIZE * PATCH_SIZE;
    localparam int ROW_W   = idx_width(PATCH_SIZE);
    localparam int COL_W   = idx_width(IMG_WIDTH);
    localparam int BAND_W  = idx_width(NBANDS);
    localparam int PCOL_W  = idx_width(PIR);
    localparam int POS_W   = idx_width(PV);
    localparam int PATCH_W = idx_width(TP);

    bank_status_t      full, full_n;
    logic              wr_bank, rd_bank, rd_bank_n;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [BAND_W-1:0] wr_band;
    logic [POS_W-1:0]  rd_pos, rd_pos_n;
    logic [PCOL_W-1:0] rd_pcol, rd_pcol_n;
    logic [BAND_W-1:0] rd_band, rd_band_n;
    logic              resync;
    logic              in_fire, out_fire, at_origin, sof_bad, band_fill, rd_done;
    logic [ROW_W-1:0]  buf_wr_row, buf_rd_row;
    logic [COL_W-1:0]  buf_wr_col, buf_rd_col;
    logic [PW-1:0]     rd_pixel;

    assign in_ready  = !full[wr_bank] && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign at_origin = (wr_row == '0) && (wr_col == '0) && (wr_band == '0);
    assign sof_bad   = in_fire && in_sof && !at_origin;
    assign band_fill = in_fire && !sof_bad && (wr_row == ROW_W'(PATCH_SIZE-1))
                       && (wr_col == COL_W'(IMG_WIDTH-1));
    assign rd_done   = out_fire && (rd_pos == POS_W'(PV-1)) && (rd_pcol == PCOL_W'(PIR-1));

    // A misplaced start-of-frame pixel is rewritten as pixel (0,0) of the current bank.
    assign buf_wr_row = sof_bad ? '0 : wr_row;
    assign buf_wr_col = sof_bad ? '0 : wr_col;
    assign buf_rd_row = rd_pos[POS_W-1:ROW_W];
    assign buf_rd_col = COL_W'({rd_pcol, rd_pos[ROW_W-1:0]});

    assign out_pixel   = out_valid ? rd_pixel : '0;
    assign out_pos_idx = rd_pos;

    patch_band_buffer #(
        .PIXEL_WIDTH (PW),
        .PATCH_SIZE  (PATCH_SIZE),
        .IMG_WIDTH   (IMG_WIDTH)
    ) u_buf (
        .clk      (clk),
        .wr_en    (in_fire),
        .wr_bank  (wr_bank),
        .wr_row   (buf_wr_row),
        .wr_col   (buf_wr_col),
        .wr_pixel (in_pixel),
        .rd_bank  (rd_bank),
        .rd_row   (buf_rd_row),
        .rd_col   (buf_rd_col),
        .rd_pixel (rd_pixel)
    );

    // Raster-order write counters and the sof error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_band <= '0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= sof_bad;
            if (sof_bad) begin
                wr_row  <= '0;
                wr_col  <= COL_W'(1);
                wr_band <= '0;
            end else if (in_fire) begin
                if (wr_col == COL_W'(IMG_WIDTH-1)) begin
                    wr_col <= '0;
                    if (wr_row == ROW_W'(PATCH_SIZE-1)) begin
                        wr_row  <= '0;
                        wr_bank <= ~wr_bank;
                        wr_band <= (wr_band == BAND_W'(NBANDS-1)) ? '0 : wr_band + BAND_W'(1);
                    end else begin
                        wr_row <= wr_row + ROW_W'(1);
                    end
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end
        end
    end

    // Next-state of bank flags and patch-major read counters.
    always_comb begin
        full_n    = full;
        rd_bank_n = rd_bank;
        rd_pos_n  = rd_pos;
        rd_pcol_n = rd_pcol;
        rd_band_n = rd_band;
        if (band_fill) begin
            full_n[wr_bank] = 1'b1;
        end else begin
            full_n[wr_bank] = full[wr_bank];
        end
        if (out_fire) begin
            if (rd_pos == POS_W'(PV-1)) begin
                rd_pos_n  = '0;
                rd_pcol_n = (rd_pcol == PCOL_W'(PIR-1)) ? '0 : rd_pcol + PCOL_W'(1);
            end else begin
                rd_pos_n = rd_pos + POS_W'(1);
            end
        end else begin
            rd_pos_n = rd_pos;
        end
        // Banks queued before a resync keep their old-frame indices, then the band restarts.
        if (rd_done) begin
            full_n[rd_bank] = 1'b0;
            rd_bank_n       = ~rd_bank;
            rd_band_n       = (resync || sof_bad || rd_band == BAND_W'(NBANDS-1))
                              ? '0 : rd_band + BAND_W'(1);
        end else if (sof_bad && !full[rd_bank]) begin
            rd_band_n = '0;
        end else begin
            rd_band_n = rd_band;
        end
    end

    // Read-side state and registered output qualifiers.
    always_ff @(posedge clk) begin
        if (reset) begin
            full           <= '0;
            rd_bank        <= 1'b0;
            rd_pos         <= '0;
            rd_pcol        <= '0;
            rd_band        <= '0;
            resync         <= 1'b0;
            out_valid      <= 1'b0;
            out_patch_idx  <= '0;
            out_last_patch <= 1'b0;
            out_last_frame <= 1'b0;
        end else begin
            full           <= full_n;
            rd_bank        <= rd_bank_n;
            rd_pos         <= rd_pos_n;
            rd_pcol        <= rd_pcol_n;
            rd_band        <= rd_band_n;
            resync         <= rd_done ? 1'b0 : (resync || (sof_bad && full[rd_bank]));
            out_valid      <= full_n[rd_bank_n];
            out_patch_idx  <= PATCH_W'(rd_band_n) * PATCH_W'(PIR) + PATCH_W'(rd_pcol_n);
            out_last_patch <= full_n[rd_bank_n] && (rd_pos_n == POS_W'(PV-1));
            out_last_frame <= full_n[rd_bank_n] && (rd_pos_n == POS_W'(PV-1))
                              && (rd_pcol_n == PCOL_W'(PIR-1))
                              && (rd_band_n == BAND_W'(NBANDS-1));
        end
    end

endmodule
